// File: rtl/tqvp_hx2003_pulse_receiver.sv
// TinyQV pulse-train receiver: measures each pulse on ui_in[RX_PIN] and packs 2-bit symbols.
// Optional glitch filter enabled by defining PULSE_RX_GLITCH_FILTER_EN.
module tqvp_hx2003_pulse_receiver #(
    parameter int unsigned NUM_DATA_REG = 4,
    parameter int unsigned RX_PIN       = 3,
    parameter int unsigned FILT_LEN     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam logic [7:0] Capacity = 8'(16 * NUM_DATA_REG);

    typedef enum logic [1:0] {StIdle, StArmed, StMeasure, StDone} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cfg_q;
    logic [23:0] thr_q;
    logic        line_d_q;
    logic [15:0] pcnt_q, pcnt_d;
    logic [7:0]  dur_q, dur_d;
    logic [7:0]  count_q, count_d;
    logic        done_q, done_d, full_q, full_d;
    logic [31:0] mem_q [NUM_DATA_REG];
    logic [31:0] mem_d [NUM_DATA_REG];

    logic        enable, invert, idle_level, irq_en;
    logic [3:0]  prescaler;
    logic        raw, line, edge_det, tick, busy;
    logic [15:0] pmask, pbase;
    logic [7:0]  dur_base, thr_sel;
    logic [1:0]  sym;
    logic        wr, cfg_wr, thr_wr, stat_clr;

    assign enable     = cfg_q[0];
    assign invert     = cfg_q[1];
    assign idle_level = cfg_q[2];
    assign irq_en     = cfg_q[3];
    assign prescaler  = cfg_q[7:4];

    assign raw = ui_in[RX_PIN] ^ invert;

`ifdef PULSE_RX_GLITCH_FILTER_EN
    logic       filt_q;
    logic [7:0] fcnt_q;

    // Line only follows raw after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else if (raw == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == 8'(FILT_LEN - 1)) begin
            filt_q <= raw;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 8'd1;
        end
    end
    assign line = filt_q;
`else
    assign line = raw;
`endif

    assign edge_det = line != line_d_q;
    assign busy     = state_q == StMeasure;

    // The edge cycle itself is the first prescaled cycle of the new pulse.
    assign pmask    = (16'd1 << prescaler) - 16'd1;
    assign pbase    = edge_det ? 16'd0 : pcnt_q;
    assign tick     = pbase == pmask;
    assign dur_base = edge_det ? 8'd0 : dur_q;
    assign thr_sel  = line_d_q ? thr_q[15:8] : thr_q[7:0];
    assign sym      = {line_d_q, dur_q > thr_sel};

    assign wr       = (data_write_n == 2'b10) && !address[5];
    assign cfg_wr   = wr && (address[3:2] == 2'd0);
    assign thr_wr   = wr && (address[3:2] == 2'd1);
    assign stat_clr = wr && (address[3:2] == 2'd2) && data_in[0];

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        dur_d   = dur_q;
        count_d = count_q;
        done_d  = done_q;
        full_d  = full_q;
        mem_d   = mem_q;

        if (state_q != StIdle) begin
            pcnt_d = tick ? 16'd0 : pbase + 16'd1;
            dur_d  = (tick && dur_base != 8'hFF) ? dur_base + 8'd1 : dur_base;
        end

        if (stat_clr) begin
            done_d  = 1'b0;
            full_d  = 1'b0;
            count_d = '0;
            if (state_q != StIdle) state_d = StArmed;
        end

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    count_d = '0;
                    done_d  = 1'b0;
                    full_d  = 1'b0;
                    for (int unsigned i = 0; i < NUM_DATA_REG; i++) mem_d[i] = '0;
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (line != idle_level) state_d = StMeasure;
            end
            StMeasure: begin
                if (edge_det) begin
                    for (int unsigned i = 0; i < NUM_DATA_REG; i++) begin
                        if (count_q[6:4] == 3'(i)) mem_d[i][{count_q[3:0], 1'b0} +: 2] = sym;
                    end
                    count_d = count_q + 8'd1;
                    if (count_q + 8'd1 == Capacity) begin
                        full_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end else if (line == idle_level && thr_q[23:16] != 8'd0 &&
                             dur_q == thr_q[23:16]) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: ;
            default: state_d = StIdle;
        endcase

        if (!enable) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cfg_q    <= '0;
            thr_q    <= '0;
            line_d_q <= 1'b0;
            pcnt_q   <= '0;
            dur_q    <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            full_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_DATA_REG; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            line_d_q <= line;
            pcnt_q   <= pcnt_d;
            dur_q    <= dur_d;
            count_q  <= count_d;
            done_q   <= done_d;
            full_q   <= full_d;
            mem_q    <= mem_d;
            if (cfg_wr) cfg_q <= data_in[7:0];
            if (thr_wr) thr_q <= data_in[23:0];
        end
    end

    always_comb begin
        data_out = '0;
        if (address[5]) begin
            for (int unsigned i = 0; i < NUM_DATA_REG; i++) begin
                if (address[4:2] == 3'(i)) data_out = mem_q[i];
            end
        end else begin
            case (address[3:2])
                2'd0:    data_out = {24'd0, cfg_q};
                2'd1:    data_out = {8'd0, thr_q};
                2'd2:    data_out = {17'd0, count_q[6:0], 5'd0, full_q, done_q, busy};
                default: data_out = '0;
            endcase
        end
    end

    assign uo_out         = {5'd0, line, busy, 1'b0};
    assign data_ready     = 1'b1;
    assign user_interrupt = done_q & irq_en;

    logic unused_sig;
    assign unused_sig = ^{data_read_n, data_in[31:24], address[1:0], ui_in, 32'(FILT_LEN)};

endmodule

// File: tb/tb_tqvp_hx2003_pulse_receiver.sv
// Directed bench for the pulse receiver (default build, no glitch filter).
module tb_tqvp_hx2003_pulse_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int n_cmp  = 0;
    int n_fail = 0;

    assign ui_in = {4'd0, rx, 3'd0};

    always #5 clk = ~clk;

    tqvp_hx2003_pulse_receiver #(
        .NUM_DATA_REG(4),
        .RX_PIN(3),
        .FILT_LEN(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ui_in(ui_in),
        .uo_out(uo_out),
        .address(address),
        .data_in(data_in),
        .data_write_n(data_write_n),
        .data_read_n(data_read_n),
        .data_out(data_out),
        .data_ready(data_ready),
        .user_interrupt(user_interrupt)
    );

    task automatic wr32(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        address      = a;
        data_in      = d;
        data_write_n = 2'b10;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic rd32(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        address     = a;
        data_read_n = 2'b10;
        #1;
        d           = data_out;
        data_read_n = 2'b11;
    endtask

    task automatic drive(input logic level, input int n);
        rx = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic rearm(input logic [7:0] cfg);
        wr32(6'h00, 32'd0);
        wr32(6'h00, {24'd0, cfg});
        drive(1'b0, 2);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rd32(6'h00, v);
        n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_cfg: got %h want 0", v); end
        rd32(6'h08, v);
        n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_stat: got %h want 0", v); end
        rd32(6'h20, v);
        n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_mem0: got %h want 0", v); end
        n_cmp++; if (uo_out !== 8'd0) begin n_fail++; $display("FAIL reset_uo: got %h want 0", uo_out); end
        n_cmp++;
        if (user_interrupt !== 1'b0 || data_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_irq_ready: got %b%b want 01", user_interrupt, data_ready);
        end
        wr32(6'h0C, 32'hFFFF_FFFF);
        rd32(6'h0C, v);
        n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped: got %h want 0", v); end
    endtask

    task automatic test_basic;
        logic [31:0] v;
        wr32(6'h04, 32'h0032_0A0A);
        rearm(8'h09);
        drive(1'b1, 20);
        n_cmp++; if (uo_out !== 8'h06) begin n_fail++; $display("FAIL basic_busy: got %h want 06", uo_out); end
        drive(1'b0, 5);
        drive(1'b1, 5);
        drive(1'b0, 60);
        rd32(6'h08, v);
        n_cmp++; if (v !== 32'h302) begin n_fail++; $display("FAIL basic_stat: got %h want 302", v); end
        rd32(6'h20, v);
        n_cmp++; if (v !== 32'h23) begin n_fail++; $display("FAIL basic_word0: got %h want 23", v); end
        n_cmp++; if (user_interrupt !== 1'b1) begin n_fail++; $display("FAIL basic_irq: got %b want 1", user_interrupt); end
    endtask

    task automatic test_stat_clear;
        logic [31:0] v;
        wr32(6'h08, 32'd1);
        rd32(6'h08, v);
        n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL clear_stat: got %h want 0", v); end
        n_cmp++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL clear_irq: got %b want 0", user_interrupt); end
        drive(1'b1, 4);
        drive(1'b0, 60);
        rd32(6'h08, v);
        n_cmp++; if (v !== 32'h102) begin n_fail++; $display("FAIL clear_restat: got %h want 102", v); end
        rd32(6'h20, v);
        n_cmp++; if (v !== 32'h22) begin n_fail++; $display("FAIL clear_word0: got %h want 22", v); end
    endtask

    task automatic test_full;
        logic [31:0] v;
        wr32(6'h08, 32'd1);
        for (int k = 0; k < 70; k++) drive((k % 2 == 0) ? 1'b1 : 1'b0, 3);
        drive(1'b0, 10);
        rd32(6'h08, v);
        n_cmp++; if (v !== 32'h4006) begin n_fail++; $display("FAIL full_stat: got %h want 4006", v); end
        rd32(6'h20, v);
        n_cmp++; if (v !== 32'h2222_2222) begin n_fail++; $display("FAIL full_word0: got %h want 22222222", v); end
        rd32(6'h2C, v);
        n_cmp++; if (v !== 32'h2222_2222) begin n_fail++; $display("FAIL full_word3: got %h want 22222222", v); end
        n_cmp++; if (user_interrupt !== 1'b1) begin n_fail++; $display("FAIL full_irq: got %b want 1", user_interrupt); end
    endtask

    task automatic test_invert;
        logic [31:0] v;
        wr32(6'h04, 32'h0014_0909);
        rearm(8'h2F);
        drive(1'b1, 8);
        drive(1'b0, 40);
        drive(1'b1, 4);
        drive(1'b0, 100);
        rd32(6'h08, v);
        n_cmp++; if (v !== 32'h302) begin n_fail++; $display("FAIL invert_stat: got %h want 302", v); end
        rd32(6'h20, v);
        n_cmp++; if (v !== 32'h0C) begin n_fail++; $display("FAIL invert_word0: got %h want 0c", v); end
        n_cmp++; if (uo_out !== 8'h04) begin n_fail++; $display("FAIL invert_uo: got %h want 04", uo_out); end
    endtask

    task automatic test_disable;
        logic [31:0] v;
        wr32(6'h04, 32'h0032_0A0A);
        rearm(8'h01);
        drive(1'b1, 20);
        drive(1'b0, 3);
        wr32(6'h00, 32'd0);
        n_cmp++; if (uo_out[1] !== 1'b1) begin n_fail++; $display("FAIL disable_busy_same: got %b want 1", uo_out[1]); end
        @(negedge clk);
        n_cmp++; if (uo_out[1] !== 1'b0) begin n_fail++; $display("FAIL disable_busy_next: got %b want 0", uo_out[1]); end
        rd32(6'h08, v);
        n_cmp++; if (v !== 32'h100) begin n_fail++; $display("FAIL disable_stat: got %h want 100", v); end
        rd32(6'h20, v);
        n_cmp++; if (v !== 32'h3) begin n_fail++; $display("FAIL disable_word0: got %h want 3", v); end
    endtask

    task automatic test_spike;
        logic [31:0] v;
        rearm(8'h09);
        drive(1'b1, 20);
        drive(1'b0, 10);
        drive(1'b1, 2);
        drive(1'b0, 60);
        rd32(6'h08, v);
        n_cmp++; if (v !== 32'h302) begin n_fail++; $display("FAIL spike_stat: got %h want 302", v); end
        rd32(6'h20, v);
        n_cmp++; if (v !== 32'h23) begin n_fail++; $display("FAIL spike_word0: got %h want 23", v); end
    endtask

    initial begin
        rst_n        = 1'b0;
        rx           = 1'b0;
        address      = '0;
        data_in      = '0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset;
        test_basic;
        test_stat_clear;
        test_full;
        test_invert;
        test_disable;
        test_spike;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
